// File: rtl/bht_update_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : bht_update_ctrl
// Purpose  : Write-port controller for the fetch-stage branch-history table.
//            Sweeps the whole table to zero after reset and on flush-all,
//            then buffers branch-verify updates from two execute-stage slots
//            in a small FIFO and drains them one BHT write per cycle.
// Ports    : clk, resetn (async, active low)
//            req0_* / req1_*  : valid/ready/idx/data update slots (0 = older)
//            flush_all_req    : one-cycle pulse, invalidates the whole table
//            bht_we/waddr/wdata : BHT RAM write port
//            busy             : table contents not valid (state != RUN)
//            fifo_count       : current update-FIFO occupancy
// Options  : `define BHT_UPDATE_COALESCE_EN to merge an accepted request into
//            the FIFO tail (or merge a same-index req0/req1 pair) in place.
// Revision : 1.0 - initial release
// ============================================================================
module bht_update_ctrl #(
  parameter int IDX_W      = 10,
  parameter int ENTRY_W    = 58,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          resetn,
  input  logic                          req0_valid,
  output logic                          req0_ready,
  input  logic [IDX_W-1:0]              req0_idx,
  input  logic [ENTRY_W-1:0]            req0_data,
  input  logic                          req1_valid,
  output logic                          req1_ready,
  input  logic [IDX_W-1:0]              req1_idx,
  input  logic [ENTRY_W-1:0]            req1_data,
  input  logic                          flush_all_req,
  output logic                          bht_we,
  output logic [IDX_W-1:0]              bht_waddr,
  output logic [ENTRY_W-1:0]            bht_wdata,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  localparam logic [CNT_W-1:0] c_DEPTH = CNT_W'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] c_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] c_TWO   = CNT_W'(2);

  localparam logic [1:0] c_ST_INIT  = 2'd0;
  localparam logic [1:0] c_ST_CLEAR = 2'd1;
  localparam logic [1:0] c_ST_RUN   = 2'd2;

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic [1:0]         r_state;
  logic [IDX_W-1:0]   r_cnt;
  logic [PTR_W-1:0]   r_wr_ptr;
  logic [PTR_W-1:0]   r_rd_ptr;
  logic [CNT_W-1:0]   r_count;
  logic [IDX_W-1:0]   r_hold_addr;
  logic [ENTRY_W-1:0] r_hold_data;

  logic [IDX_W-1:0]   r_mem_idx  [FIFO_DEPTH];
  logic [ENTRY_W-1:0] r_mem_data [FIFO_DEPTH];

  // --------------------------------------------------------------------------
  // Handshake / FIFO control
  // --------------------------------------------------------------------------
  logic             w_run;
  logic             w_clear;
  logic [CNT_W-1:0] w_free;
  logic             w_rdy0;
  logic             w_rdy1;
  logic             w_acc0;
  logic             w_acc1;
  logic             w_pop;
  logic             w_we;
  logic [IDX_W-1:0] w_waddr;
  logic [ENTRY_W-1:0] w_wdata;

  assign w_run   = (r_state == c_ST_RUN);
  assign w_clear = (r_state == c_ST_CLEAR);

  // Free space comes from the registered count only; a pop in this cycle
  // does not make room for an accept in the same cycle.
  assign w_free = c_DEPTH - r_count;
  assign w_rdy0 = w_run && (w_free >= c_ONE);
  assign w_rdy1 = w_run && ((w_free >= c_TWO) || ((w_free == c_ONE) && !req0_valid));
  assign w_acc0 = req0_valid && w_rdy0;
  assign w_acc1 = req1_valid && w_rdy1;

  assign w_pop  = w_run && (r_count != '0);

  // FIFO write plan for this cycle: which slot each request lands in and
  // how many new slots get allocated.
  logic             w_wr0_en;
  logic             w_wr1_en;
  logic [PTR_W-1:0] w_wr0_ptr;
  logic [PTR_W-1:0] w_wr1_ptr;
  logic [1:0]       w_alloc;

`ifdef BHT_UPDATE_COALESCE_EN
  logic [PTR_W-1:0] w_tail_ptr;
  logic             w_tail_ok;
  logic             w_hit0;
  logic             w_hit1;

  // The tail is only safe to overwrite when it is not the head being
  // popped this cycle, hence the occupancy of at least two.
  assign w_tail_ptr = r_wr_ptr - PTR_W'(1);
  assign w_tail_ok  = (r_count >= c_TWO);
  assign w_hit0     = w_tail_ok && (req0_idx == r_mem_idx[w_tail_ptr]);
  assign w_hit1     = w_tail_ok && (req1_idx == r_mem_idx[w_tail_ptr]);

  always_comb begin
    w_wr0_en  = 1'b0;
    w_wr1_en  = 1'b0;
    w_wr0_ptr = r_wr_ptr;
    w_wr1_ptr = r_wr_ptr;
    w_alloc   = 2'd0;
    if (w_acc0 && w_acc1 && (req0_idx == req1_idx)) begin
      // Younger request supersedes the older one: store req1 only.
      w_wr1_en = 1'b1;
      if (w_hit1) begin
        w_wr1_ptr = w_tail_ptr;
      end else begin
        w_wr1_ptr = r_wr_ptr;
        w_alloc   = 2'd1;
      end
    end else begin
      if (w_acc0) begin
        w_wr0_en = 1'b1;
        if (w_hit0) begin
          w_wr0_ptr = w_tail_ptr;
        end else begin
          w_wr0_ptr = r_wr_ptr;
          w_alloc   = 2'd1;
        end
      end
      if (w_acc1) begin
        w_wr1_en = 1'b1;
        // With req0 also accepted (different index) the tail is req0's
        // entry, so req1 can only coalesce when it arrives alone.
        if (!w_acc0 && w_hit1) begin
          w_wr1_ptr = w_tail_ptr;
        end else begin
          w_wr1_ptr = r_wr_ptr + PTR_W'(w_alloc);
          w_alloc   = w_alloc + 2'd1;
        end
      end
    end
  end
`else
  always_comb begin
    w_wr0_en  = w_acc0;
    w_wr1_en  = w_acc1;
    w_wr0_ptr = r_wr_ptr;
    // req0 goes in first, req1 directly behind it.
    w_wr1_ptr = w_acc0 ? (r_wr_ptr + PTR_W'(1)) : r_wr_ptr;
    w_alloc   = {1'b0, w_acc0} + {1'b0, w_acc1};
  end
`endif

  // --------------------------------------------------------------------------
  // Write-port mux
  // --------------------------------------------------------------------------
  always_comb begin
    w_we    = 1'b0;
    w_waddr = r_hold_addr;
    w_wdata = r_hold_data;
    if (w_clear) begin
      w_we    = 1'b1;
      w_waddr = r_cnt;
      w_wdata = '0;
    end else if (w_pop) begin
      w_we    = 1'b1;
      w_waddr = r_mem_idx[r_rd_ptr];
      w_wdata = r_mem_data[r_rd_ptr];
    end
  end

  // --------------------------------------------------------------------------
  // Control FSM, sweep counter, FIFO pointers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state     <= c_ST_INIT;
      r_cnt       <= '0;
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_hold_addr <= '0;
      r_hold_data <= '0;
    end else begin
      // Idle write-port value is whatever was last driven with we=1.
      if (w_we) begin
        r_hold_addr <= w_waddr;
        r_hold_data <= w_wdata;
      end

      case (r_state)
        c_ST_INIT: begin
          r_state <= c_ST_CLEAR;
          r_cnt   <= '0;
        end

        c_ST_CLEAR: begin
          if (flush_all_req) begin
            r_cnt <= '0;
          end else if (r_cnt == '1) begin
            r_state <= c_ST_RUN;
          end else begin
            r_cnt <= r_cnt + IDX_W'(1);
          end
        end

        c_ST_RUN: begin
          if (flush_all_req) begin
            // Anything accepted this cycle is discarded along with the queue.
            r_state  <= c_ST_CLEAR;
            r_cnt    <= '0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
          end else begin
            r_wr_ptr <= r_wr_ptr + PTR_W'(w_alloc);
            r_rd_ptr <= r_rd_ptr + PTR_W'(w_pop);
            r_count  <= r_count + CNT_W'(w_alloc) - CNT_W'(w_pop);
          end
        end

        default: begin
          r_state <= c_ST_INIT;
          r_cnt   <= '0;
        end
      endcase
    end
  end

  // FIFO storage needs no reset: occupancy and pointers define validity.
  always_ff @(posedge clk) begin
    if (w_wr0_en) begin
      r_mem_idx[w_wr0_ptr]  <= req0_idx;
      r_mem_data[w_wr0_ptr] <= req0_data;
    end
    if (w_wr1_en) begin
      r_mem_idx[w_wr1_ptr]  <= req1_idx;
      r_mem_data[w_wr1_ptr] <= req1_data;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign req0_ready = w_rdy0;
  assign req1_ready = w_rdy1;
  assign bht_we     = w_we;
  assign bht_waddr  = w_waddr;
  assign bht_wdata  = w_wdata;
  assign busy       = !w_run;
  assign fifo_count = r_count;

endmodule
`default_nettype wire

// File: tb/tb_bht_update_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_bht_update_ctrl
// Purpose  : Directed self-checking bench for bht_update_ctrl: reset sweep,
//            dual enqueue, FIFO back-pressure, same-index pair, flush-all
//            (including restart mid-sweep) and asynchronous reset mid-drain.
// Revision : 1.0 - initial release
// ============================================================================
module tb_bht_update_ctrl;

  localparam int IDX_W      = 10;
  localparam int ENTRY_W    = 58;
  localparam int FIFO_DEPTH = 4;

  logic                 clk = 1'b0;
  logic                 resetn;
  logic                 req0_valid, req1_valid;
  logic                 req0_ready, req1_ready;
  logic [IDX_W-1:0]     req0_idx, req1_idx;
  logic [ENTRY_W-1:0]   req0_data, req1_data;
  logic                 flush_all_req;
  logic                 bht_we;
  logic [IDX_W-1:0]     bht_waddr;
  logic [ENTRY_W-1:0]   bht_wdata;
  logic                 busy;
  logic [$clog2(FIFO_DEPTH):0] fifo_count;

  int n_cmp = 0;
  int n_err = 0;

  bht_update_ctrl #(
    .IDX_W      (IDX_W),
    .ENTRY_W    (ENTRY_W),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_dut (
    .clk           (clk),
    .resetn        (resetn),
    .req0_valid    (req0_valid),
    .req0_ready    (req0_ready),
    .req0_idx      (req0_idx),
    .req0_data     (req0_data),
    .req1_valid    (req1_valid),
    .req1_ready    (req1_ready),
    .req1_idx      (req1_idx),
    .req1_data     (req1_data),
    .flush_all_req (flush_all_req),
    .bht_we        (bht_we),
    .bht_waddr     (bht_waddr),
    .bht_wdata     (bht_wdata),
    .busy          (busy),
    .fifo_count    (fifo_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [ENTRY_W-1:0] dat(input int idx);
    return 58'h2A5_0000_0000 + ENTRY_W'(idx);
  endfunction

  // Advance to 1 time unit after the next rising edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    req0_valid    = 1'b0;
    req1_valid    = 1'b0;
    flush_all_req = 1'b0;
  endtask

  task automatic drive(input logic v0, input int i0, input logic v1, input int i1);
    req0_valid = v0;
    req0_idx   = IDX_W'(i0);
    req0_data  = dat(i0);
    req1_valid = v1;
    req1_idx   = IDX_W'(i1);
    req1_data  = dat(i1);
  endtask

  task automatic chk_wr(input string tag, input logic we, input int addr, input logic [ENTRY_W-1:0] data);
    chk({tag, "_we"}, 64'(bht_we), 64'(we));
    if (we) begin
      chk({tag, "_addr"}, 64'(bht_waddr), 64'(addr));
      chk({tag, "_data"}, 64'(bht_wdata), 64'(data));
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    resetn = 1'b0;
    drive(1'b1, 1, 1'b1, 2);
    flush_all_req = 1'b0;
    #2;
    // ---------------- reset state ----------------
    chk("rst_we",    64'(bht_we), 64'd0);
    chk("rst_waddr", 64'(bht_waddr), 64'd0);
    chk("rst_wdata", 64'(bht_wdata), 64'd0);
    chk("rst_busy",  64'(busy), 64'd1);
    chk("rst_rdy0",  64'(req0_ready), 64'd0);
    chk("rst_rdy1",  64'(req1_ready), 64'd0);
    chk("rst_cnt",   64'(fifo_count), 64'd0);
    cyc();
    chk("rst_hold_busy", 64'(busy), 64'd1);
    #2 resetn = 1'b1;

    // ---------------- reset sweep ----------------
    for (int i = 0; i < 1024; i++) begin
      cyc();
      if (i == 1023) idle();
      #1;
      chk_wr("sweep", 1'b1, i, '0);
      chk("sweep_busy", 64'(busy), 64'd1);
      chk("sweep_rdy0", 64'(req0_ready), 64'd0);
      chk("sweep_rdy1", 64'(req1_ready), 64'd0);
    end
    cyc(); #1;
    chk("run_busy", 64'(busy), 64'd0);
    chk("run_we",   64'(bht_we), 64'd0);
    chk("run_cnt",  64'(fifo_count), 64'd0);

    // ---------------- dual enqueue ----------------
    drive(1'b1, 5, 1'b1, 9); #1;
    chk("dual_rdy0", 64'(req0_ready), 64'd1);
    chk("dual_rdy1", 64'(req1_ready), 64'd1);
    chk("dual_nobypass", 64'(bht_we), 64'd0);
    cyc(); idle(); #1;
    chk("dual_cnt2", 64'(fifo_count), 64'd2);
    chk_wr("dual_w0", 1'b1, 5, dat(5));
    cyc(); #1;
    chk("dual_cnt1", 64'(fifo_count), 64'd1);
    chk_wr("dual_w1", 1'b1, 9, dat(9));
    cyc(); #1;
    chk("dual_cnt0", 64'(fifo_count), 64'd0);
    chk("dual_idle_we", 64'(bht_we), 64'd0);
    chk("dual_hold_addr", 64'(bht_waddr), 64'd9);
    chk("dual_hold_data", 64'(bht_wdata), 64'(dat(9)));

    // ---------------- back-pressure: accepted 20,21,22,23,24,25 ----------------
    drive(1'b1, 20, 1'b1, 21); #1;
    chk("full_c1_rdy0", 64'(req0_ready), 64'd1);
    chk("full_c1_rdy1", 64'(req1_ready), 64'd1);
    cyc(); drive(1'b1, 22, 1'b1, 23); #1;
    chk("full_c2_cnt",  64'(fifo_count), 64'd2);
    chk("full_c2_rdy1", 64'(req1_ready), 64'd1);
    chk_wr("full_c2", 1'b1, 20, dat(20));
    cyc(); drive(1'b1, 24, 1'b1, 25); #1;
    chk("full_c3_cnt",  64'(fifo_count), 64'd3);
    chk("full_c3_rdy0", 64'(req0_ready), 64'd1);
    chk("full_c3_rdy1", 64'(req1_ready), 64'd0);
    chk_wr("full_c3", 1'b1, 21, dat(21));
    cyc(); drive(1'b1, 25, 1'b1, 26); #1;
    chk("full_c4_cnt",  64'(fifo_count), 64'd3);
    chk("full_c4_rdy1", 64'(req1_ready), 64'd0);
    chk_wr("full_c4", 1'b1, 22, dat(22));
    for (int k = 0; k < 3; k++) begin
      cyc(); idle(); #1;
      chk("full_drain_cnt", 64'(fifo_count), 64'(3 - k));
      chk_wr("full_drain", 1'b1, 23 + k, dat(23 + k));
    end
    cyc(); #1;
    chk("full_empty_we", 64'(bht_we), 64'd0);
    chk("full_empty_cnt", 64'(fifo_count), 64'd0);

    // ---------------- same-index pair ----------------
    drive(1'b1, 7, 1'b1, 7);
    req1_data = dat(1007);
    #1;
    chk("same_rdy1", 64'(req1_ready), 64'd1);
    cyc(); idle(); #1;
`ifdef BHT_UPDATE_COALESCE_EN
    chk("same_cnt", 64'(fifo_count), 64'd1);
    chk_wr("same_w", 1'b1, 7, dat(1007));
    cyc(); #1;
    chk("same_end_we", 64'(bht_we), 64'd0);
`else
    chk("same_cnt", 64'(fifo_count), 64'd2);
    chk_wr("same_wA", 1'b1, 7, dat(7));
    cyc(); #1;
    chk_wr("same_wB", 1'b1, 7, dat(1007));
    cyc(); #1;
    chk("same_end_we", 64'(bht_we), 64'd0);
`endif

    // ---------------- flush-all with 3 queued ----------------
    drive(1'b1, 30, 1'b1, 31);
    cyc(); drive(1'b1, 32, 1'b1, 33); #1;
    chk("fl_cnt2", 64'(fifo_count), 64'd2);
    cyc(); drive(1'b1, 34, 1'b0, 0); flush_all_req = 1'b1; #1;
    chk("fl_cnt3", 64'(fifo_count), 64'd3);
    chk("fl_rdy0_same_cycle", 64'(req0_ready), 64'd1);
    chk("fl_busy_pre", 64'(busy), 64'd0);
    chk_wr("fl_pre", 1'b1, 31, dat(31));
    cyc(); idle(); req0_valid = 1'b1; #1;
    chk("fl_cnt0", 64'(fifo_count), 64'd0);
    chk("fl_busy", 64'(busy), 64'd1);
    chk("fl_rdy0_after", 64'(req0_ready), 64'd0);
    chk_wr("fl_sweep0", 1'b1, 0, '0);
    for (int i = 1; i <= 300; i++) begin
      cyc();
      if (i == 300) flush_all_req = 1'b1;
      #1;
      chk("fl_sweep_addr", 64'(bht_waddr), 64'(i));
    end
    cyc(); idle(); #1;
    chk_wr("fl_restart", 1'b1, 0, '0);
    for (int i = 1; i < 1024; i++) begin
      cyc(); #1;
      chk("fl2_sweep_addr", 64'(bht_waddr), 64'(i));
      chk("fl2_busy", 64'(busy), 64'd1);
    end
    cyc(); #1;
    chk("fl_run_busy", 64'(busy), 64'd0);
    chk("fl_run_we",   64'(bht_we), 64'd0);
    chk("fl_run_cnt",  64'(fifo_count), 64'd0);

    // ---------------- async reset mid-drain ----------------
    drive(1'b1, 40, 1'b1, 41);
    cyc(); idle(); #1;
    chk("ar_cnt2", 64'(fifo_count), 64'd2);
    chk_wr("ar_pre", 1'b1, 40, dat(40));
    #1 resetn = 1'b0;
    req0_valid = 1'b1;
    #1;
    chk("ar_we",    64'(bht_we), 64'd0);
    chk("ar_waddr", 64'(bht_waddr), 64'd0);
    chk("ar_wdata", 64'(bht_wdata), 64'd0);
    chk("ar_busy",  64'(busy), 64'd1);
    chk("ar_cnt",   64'(fifo_count), 64'd0);
    chk("ar_rdy0",  64'(req0_ready), 64'd0);
    #2 resetn = 1'b1;
    idle();
    cyc(); #1;
    chk_wr("ar_resweep", 1'b1, 0, '0);
    chk("ar_resweep_cnt", 64'(fifo_count), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
